// File: rtl/image_unshear_if.sv
// Handshake bundle for image_unshear: frame control, sheared-buffer read port
// and the valid/ready pixel stream.
interface image_unshear_if #(
   parameter int unsigned AW = 20
) ();
   logic          start;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_data;
   logic          out_last;

   modport master (
      output start, output rd_data, output out_ready,
      input  busy,  input  done,    input  rd_en,     input rd_addr,
      input  out_valid, input out_data, input out_last
   );

   modport slave (
      input  start, input  rd_data, input  out_ready,
      output busy,  output done,    output rd_en,     output rd_addr,
      output out_valid, output out_data, output out_last
   );
endinterface

// File: rtl/image_unshear.sv
// Streams an un-sheared image by reading a sheared frame buffer in output raster order.
// Optional stall counter output enabled by defining IMAGE_UNSHEAR_STALLCNT_EN.
module image_unshear #(
   parameter int unsigned ROWS = 242,
   parameter int unsigned COLS = 247,
   parameter int unsigned SHX  = 77,
   parameter int unsigned SHY  = 102,
   parameter int unsigned AW   = 20
) (
   input  logic             clk,
   input  logic             rst,
   image_unshear_if.slave   bus
`ifdef IMAGE_UNSHEAR_STALLCNT_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);
   localparam int unsigned SW = COLS + (ROWS * SHX) / 256;
   localparam int unsigned RW = $clog2(ROWS + 1);
   localparam int unsigned CW = $clog2(COLS + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

   state_e            state_q, state_d;
   logic [RW-1:0]     i_q, i_d;
   logic [CW-1:0]     j_q, j_d;
   logic [7:0]        fx_q, fx_d, fy_q, fy_d;
   logic [AW-1:0]     row_base_q, row_base_d, col_term_q, col_term_d;
   logic              rd_en_q, rd_en_d, rd_last_q, rd_last_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic              dv_q, dv_last_q;
   logic              busy_q, busy_d, done_q, done_d;
   logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [7:0]        out_data_q, out_data_d;
   logic [1:0][7:0]   skid_data_q, skid_data_d;
   logic [1:0]        skid_last_q, skid_last_d;
   logic [1:0]        skid_cnt_q, skid_cnt_d;

   logic              pop_c, issue_ok_c, row_end_c, last_px_c, taken_c;
   logic [2:0]        held_c;
   logic [1:0]        n_c;
   logic [8:0]        fx_sum_c, fy_sum_c;

   // Output register plus 2-entry skid give three slots, enough to cover the
   // three-cycle issue-to-buffer loop at one pixel per cycle.
   assign pop_c      = out_valid_q && bus.out_ready;
   assign held_c     = 3'(out_valid_q) + 3'(skid_cnt_q) + 3'(rd_en_q) + 3'(dv_q);
   assign issue_ok_c = (held_c - 3'(pop_c)) < 3'd3;
   assign row_end_c  = (j_q == CW'(COLS - 1));
   assign last_px_c  = row_end_c && (i_q == RW'(ROWS - 1));
   assign fx_sum_c   = 9'(fx_q) + 9'(SHX);
   assign fy_sum_c   = 9'(fy_q) + 9'(SHY);

   // Frame FSM and incremental address generation
   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      fx_d       = fx_q;
      fy_d       = fy_q;
      row_base_d = row_base_q;
      col_term_d = col_term_q;
      rd_en_d    = 1'b0;
      rd_last_d  = 1'b0;
      rd_addr_d  = rd_addr_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_RUN;
               i_d        = '0;
               j_d        = '0;
               fx_d       = '0;
               fy_d       = '0;
               row_base_d = '0;
               col_term_d = '0;
            end
         end
         S_RUN: begin
            if (issue_ok_c) begin
               rd_en_d   = 1'b1;
               rd_last_d = last_px_c;
               rd_addr_d = row_base_q + col_term_q;
               if (row_end_c) begin
                  j_d        = '0;
                  fy_d       = '0;
                  col_term_d = '0;
                  i_d        = i_q + RW'(1);
                  fx_d       = fx_sum_c[7:0];
                  row_base_d = row_base_q + AW'(SW) + AW'(fx_sum_c[8]);
               end else begin
                  j_d        = j_q + CW'(1);
                  fy_d       = fy_sum_c[7:0];
                  col_term_d = col_term_q + (fy_sum_c[8] ? AW'(SW + 1) : AW'(1));
               end
               if (last_px_c) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop_c && out_last_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Output register refills from the skid head first, else straight from read data
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      skid_data_d = skid_data_q;
      skid_last_d = skid_last_q;
      n_c         = skid_cnt_q;
      taken_c     = 1'b0;
      if (!out_valid_q || pop_c) begin
         if (skid_cnt_q != 2'd0) begin
            out_valid_d    = 1'b1;
            out_data_d     = skid_data_q[0];
            out_last_d     = skid_last_q[0];
            skid_data_d[0] = skid_data_q[1];
            skid_last_d[0] = skid_last_q[1];
            n_c            = skid_cnt_q - 2'd1;
         end else if (dv_q) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.rd_data;
            out_last_d  = dv_last_q;
            taken_c     = 1'b1;
         end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
      end
      if (dv_q && !taken_c && (n_c < 2'd2)) begin
         skid_data_d[n_c[0]] = bus.rd_data;
         skid_last_d[n_c[0]] = dv_last_q;
         n_c                 = n_c + 2'd1;
      end
      skid_cnt_d = n_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         fx_q        <= '0;
         fy_q        <= '0;
         row_base_q  <= '0;
         col_term_q  <= '0;
         rd_en_q     <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_addr_q   <= '0;
         dv_q        <= 1'b0;
         dv_last_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         skid_data_q <= '0;
         skid_last_q <= '0;
         skid_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         fx_q        <= fx_d;
         fy_q        <= fy_d;
         row_base_q  <= row_base_d;
         col_term_q  <= col_term_d;
         rd_en_q     <= rd_en_d;
         rd_last_q   <= rd_last_d;
         rd_addr_q   <= rd_addr_d;
         dv_q        <= rd_en_q;
         dv_last_q   <= rd_last_q;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         skid_data_q <= skid_data_d;
         skid_last_q <= skid_last_d;
         skid_cnt_q  <= skid_cnt_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;

`ifdef IMAGE_UNSHEAR_STALLCNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles the downstream holds off a valid pixel
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == S_IDLE && bus.start) begin
         stall_cnt_d = '0;
      end else if (out_valid_q && !bus.out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_image_unshear.sv
// Scoreboard bench for image_unshear on a 4x4 frame (SHX=128, SHY=64, SW=6);
// the frame-buffer model returns the low byte of the requested address.
module tb_image_unshear;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int SHX  = 128;
   localparam int SHY  = 64;
   localparam int AW   = 20;
   localparam int SW   = COLS + (ROWS * SHX) / 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef IMAGE_UNSHEAR_STALLCNT_EN
   logic [31:0] stall_cnt;
`endif

   image_unshear_if #(.AW(AW)) bus ();

   image_unshear #(
      .ROWS(ROWS), .COLS(COLS), .SHX(SHX), .SHY(SHY), .AW(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
`ifdef IMAGE_UNSHEAR_STALLCNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.rd_en === 1'b1) bus.rd_data <= bus.rd_addr[7:0];
   end

   int n_checks = 0;
   int n_pass   = 0;
   int pix_cnt, done_cnt, last_idx, cyc_cnt;
   logic [AW-1:0] aq[$];
   logic [8:0]    dq[$];
   bit            hold_v = 1'b0;
   logic [8:0]    hold_val;

   function automatic int model_addr(input int i, input int j);
      return (i + (j * SHY) / 256) * SW + j + (i * SHX) / 256;
   endfunction

   // Scores the handshakes the coming edge will perform, then advances one cycle
   task automatic tick();
      logic [AW-1:0] ea;
      logic [8:0]    ed;
      if (rst !== 1'b1) begin
         if (hold_v) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_last, bus.out_data} !== hold_val)
               $display("FAIL hold_stable: got valid=%b last/data=%h, required valid=1 last/data=%h",
                        bus.out_valid, {bus.out_last, bus.out_data}, hold_val);
            else n_pass++;
         end
         if (bus.rd_en === 1'b1) begin
            n_checks++;
            if (aq.size() == 0) begin
               $display("FAIL rd_addr: got unexpected read of %0d, required no read", bus.rd_addr);
            end else begin
               ea = aq.pop_front();
               if (bus.rd_addr !== ea) $display("FAIL rd_addr: got %0d, required %0d", bus.rd_addr, ea);
               else n_pass++;
            end
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_checks++;
            if (dq.size() == 0) begin
               $display("FAIL pixel: got extra pixel %h, required none", bus.out_data);
            end else begin
               ed = dq.pop_front();
               if ({bus.out_last, bus.out_data} !== ed)
                  $display("FAIL pixel %0d: got last/data=%h, required %h",
                           pix_cnt, {bus.out_last, bus.out_data}, ed);
               else n_pass++;
            end
            if (bus.out_last === 1'b1) last_idx = pix_cnt;
            pix_cnt++;
         end
         hold_v   = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
         hold_val = {bus.out_last, bus.out_data};
      end else begin
         hold_v = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc_cnt++;
      if (bus.done === 1'b1) done_cnt++;
   endtask

   // Loads the scoreboard for one frame and pulses start; returns just after the start edge
   task automatic start_frame();
      logic [31:0] a;
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            a = 32'(model_addr(i, j));
            aq.push_back(a[AW-1:0]);
            dq.push_back({(i == ROWS - 1) && (j == COLS - 1), a[7:0]});
         end
      end
      pix_cnt   = 0;
      done_cnt  = 0;
      last_idx  = -1;
      bus.start = 1'b1;
      cyc_cnt   = -1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b1;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({bus.busy, bus.done, bus.rd_en, bus.out_valid, bus.out_last, bus.rd_addr, bus.out_data} !== '0)
         $display("FAIL reset_outputs: got busy=%b done=%b rd_en=%b valid=%b last=%b addr=%h data=%h, required all 0",
                  bus.busy, bus.done, bus.rd_en, bus.out_valid, bus.out_last, bus.rd_addr, bus.out_data);
      else n_pass++;
`ifdef IMAGE_UNSHEAR_STALLCNT_EN
      n_checks++;
      if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt: got %0d, required 0", stall_cnt);
      else n_pass++;
`endif
      rst = 1'b0;
      bus.start = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0)
         $display("FAIL reset_beats_start: got busy=%b rd_en=%b, required 0 0", bus.busy, bus.rd_en);
      else n_pass++;
   endtask

   task automatic test_stream();
      int first_v = -1, last_v = -1, nvalid = 0;
      bus.out_ready = 1'b1;
      start_frame();
      n_checks++;
      if (bus.busy !== 1'b1) $display("FAIL busy_after_start: got %b, required 1", bus.busy);
      else n_pass++;
      while (done_cnt == 0 && cyc_cnt < 100) begin
         if (bus.out_valid === 1'b1) begin
            if (first_v < 0) first_v = cyc_cnt;
            nvalid++;
            last_v = cyc_cnt;
         end
         tick();
      end
      n_checks++;
      if (first_v !== 3) $display("FAIL first_valid_latency: got %0d, required 3", first_v);
      else n_pass++;
      n_checks++;
      if (nvalid !== 16 || last_v - first_v !== 15)
         $display("FAIL valid_run: got %0d valid over span %0d, required 16 over 15", nvalid, last_v - first_v);
      else n_pass++;
      n_checks++;
      if (done_cnt !== 1 || cyc_cnt !== last_v + 1 || bus.busy !== 1'b0)
         $display("FAIL done_timing: got done_cnt=%0d at cycle %0d busy=%b, required 1 at %0d busy=0",
                  done_cnt, cyc_cnt, bus.busy, last_v + 1);
      else n_pass++;
      n_checks++;
      if (pix_cnt !== 16 || last_idx !== 15 || aq.size() != 0 || dq.size() != 0)
         $display("FAIL stream_count: got pix=%0d last_idx=%0d left=%0d/%0d, required 16 15 0/0",
                  pix_cnt, last_idx, aq.size(), dq.size());
      else n_pass++;
      tick();
      n_checks++;
      if (bus.done !== 1'b0 || done_cnt !== 1) $display("FAIL done_pulse_width: got done=%b count=%0d, required 0 1", bus.done, done_cnt);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int stalls = 0;
      start_frame();
`ifdef IMAGE_UNSHEAR_STALLCNT_EN
      n_checks++;
      if (stall_cnt !== 32'd0) $display("FAIL stall_cnt_clear: got %0d, required 0", stall_cnt);
      else n_pass++;
`endif
      while (done_cnt == 0 && cyc_cnt < 400) begin
         bus.out_ready = ($urandom_range(0, 2) == 0);
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) stalls++;
         tick();
      end
      bus.out_ready = 1'b1;
      n_checks++;
      if (done_cnt !== 1 || pix_cnt !== 16 || last_idx !== 15 || dq.size() != 0)
         $display("FAIL backpressure_frame: got done=%0d pix=%0d last_idx=%0d left=%0d, required 1 16 15 0",
                  done_cnt, pix_cnt, last_idx, dq.size());
      else n_pass++;
`ifdef IMAGE_UNSHEAR_STALLCNT_EN
      n_checks++;
      if (stall_cnt !== 32'(stalls)) $display("FAIL stall_cnt: got %0d, required %0d", stall_cnt, stalls);
      else n_pass++;
`endif
   endtask

   task automatic test_restart_ignored();
      bit pulsed = 1'b0;
      bus.out_ready = 1'b1;
      start_frame();
      while (done_cnt == 0 && cyc_cnt < 100) begin
         if (pix_cnt == 5 && !pulsed) begin
            bus.start = 1'b1;
            pulsed = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         tick();
      end
      bus.start = 1'b0;
      repeat (6) tick();
      n_checks++;
      if (done_cnt !== 1 || pix_cnt !== 16 || last_idx !== 15 || bus.busy !== 1'b0)
         $display("FAIL restart_ignored: got done=%0d pix=%0d last_idx=%0d busy=%b, required 1 16 15 0",
                  done_cnt, pix_cnt, last_idx, bus.busy);
      else n_pass++;
   endtask

   task automatic test_rst_mid();
      bit saw = 1'b0;
      bus.out_ready = 1'b1;
      start_frame();
      while (pix_cnt < 7 && cyc_cnt < 100) tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({bus.busy, bus.done, bus.rd_en, bus.out_valid, bus.out_last, bus.rd_addr, bus.out_data} !== '0)
         $display("FAIL mid_reset_outputs: got busy=%b done=%b rd_en=%b valid=%b last=%b addr=%h data=%h, required all 0",
                  bus.busy, bus.done, bus.rd_en, bus.out_valid, bus.out_last, bus.rd_addr, bus.out_data);
      else n_pass++;
      rst = 1'b0;
      aq.delete();
      dq.delete();
      repeat (5) begin
         if (bus.out_valid === 1'b1 || bus.done === 1'b1 || bus.busy === 1'b1) saw = 1'b1;
         tick();
      end
      n_checks++;
      if (saw || done_cnt !== 0)
         $display("FAIL mid_reset_quiet: got activity=%b done=%0d, required 0 0", saw, done_cnt);
      else n_pass++;
      start_frame();
      while (done_cnt == 0 && cyc_cnt < 100) tick();
      n_checks++;
      if (done_cnt !== 1 || pix_cnt !== 16 || last_idx !== 15 || aq.size() != 0 || dq.size() != 0)
         $display("FAIL frame_after_reset: got done=%0d pix=%0d last_idx=%0d left=%0d/%0d, required 1 16 15 0/0",
                  done_cnt, pix_cnt, last_idx, aq.size(), dq.size());
      else n_pass++;
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
      cyc_cnt       = 0;
      pix_cnt       = 0;
      done_cnt      = 0;
      last_idx      = -1;
      test_reset();
      test_stream();
      test_backpressure();
      test_restart_ignored();
      test_rst_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by time limit, required finish");
      $fatal(1);
   end
endmodule
